// File: rtl/load_ab_lanes.sv
//==============================================================================
// Module      : load_ab_lanes
// Description : Per-PE operand loader for the linear matrix-multiply array.
//               Captures this PE's slice of each A tile into a double-buffered
//               store, forwards foreign A words and all B words downstream,
//               and streams (A[LANES], B) pairs to the MAC lanes.
//               Optional macro LOAD_AB_LANES_STATS_EN adds stall_ab/starve_b.
// Revision    : 1.0 - initial multi-lane release
//==============================================================================
`default_nettype none

module load_ab_lanes #(
  parameter int D_WIDTH      = 64,
  parameter int LANES        = 2,
  parameter int A_NUM_WIDTH  = 4,
  parameter int A_PART_WIDTH = 2,
  parameter int B_NUM_WIDTH  = 3,
  parameter int RD_DELAY     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [A_NUM_WIDTH-A_PART_WIDTH-1:0]   pid,
  input  logic [D_WIDTH-1:0]                    a_in_data,
  input  logic                                  a_in_valid,
  output logic                                  a_in_ready,
  output logic [D_WIDTH-1:0]                    a_fwd_data,
  output logic                                  a_fwd_valid,
  input  logic                                  a_fwd_ready,
  input  logic [D_WIDTH-1:0]                    b_in_data,
  input  logic                                  b_in_valid,
  output logic                                  b_in_ready,
  output logic [D_WIDTH-1:0]                    b_fwd_data,
  output logic                                  b_fwd_valid,
  input  logic                                  b_fwd_ready,
  output logic [LANES*D_WIDTH-1:0]              ab_a_data,
  output logic [D_WIDTH-1:0]                    ab_b_data,
  output logic                                  ab_valid,
  input  logic                                  ab_ready,
  output logic                                  ab_last,
  output logic [15:0]                           tiles_done
`ifdef LOAD_AB_LANES_STATS_EN
  ,
  output logic [31:0]                           stall_ab,
  output logic [31:0]                           starve_b
`endif
);

  localparam int PID_W  = A_NUM_WIDTH - A_PART_WIDTH;
  localparam int PART   = 1 << A_PART_WIDTH;
  localparam int BEATS  = PART / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEPTH  = RD_DELAY + 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1) + 1;
  localparam int AW     = LANES * D_WIDTH;
  localparam logic [BEAT_W-1:0]      BEAT_MAX = BEAT_W'(BEATS - 1);
  localparam logic [B_NUM_WIDTH-1:0] B_MAX    = '1;
  localparam logic [A_NUM_WIDTH-1:0] A_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [A_NUM_WIDTH-1:0]   a_idx_q, a_idx_d;
  logic [PID_W-1:0]         pid_q, pid_d, pid_lat;
  logic                     load_bank_q, load_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [1:0]               full_q, full_d;
  logic [B_NUM_WIDTH-1:0]   b_idx_q, b_idx_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [D_WIDTH-1:0]       b_hold_q, b_hold_d;
  logic [D_WIDTH-1:0]       mem_q [2][PART];
  logic [D_WIDTH-1:0]       mem_d [2][PART];
  logic [RD_DELAY-1:0]      p_v_q, p_v_d, p_l_q, p_l_d;
  logic [AW-1:0]            p_a_q [RD_DELAY];
  logic [AW-1:0]            p_a_d [RD_DELAY];
  logic [D_WIDTH-1:0]       p_b_q [RD_DELAY];
  logic [D_WIDTH-1:0]       p_b_d [RD_DELAY];
  logic [AW-1:0]            f_a_q [DEPTH];
  logic [AW-1:0]            f_a_d [DEPTH];
  logic [D_WIDTH-1:0]       f_b_q [DEPTH];
  logic [D_WIDTH-1:0]       f_b_d [DEPTH];
  logic [DEPTH-1:0]         f_l_q, f_l_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, inflight;
  logic [15:0]              tiles_q, tiles_d;

  logic                     own, load_full, a_acc, wrap, rel;
  logic                     credit, issue, iss_last, push, pop;
  logic [AW-1:0]            iss_a;
  logic [D_WIDTH-1:0]       iss_b;
  logic [A_PART_WIDTH-1:0]  rd_idx;

  assign a_fwd_data = a_in_data;
  assign b_fwd_data = b_in_data;
  assign ab_valid   = (cnt_q != '0);
  assign ab_a_data  = f_a_q[rd_ptr_q];
  assign ab_b_data  = f_b_q[rd_ptr_q];
  assign ab_last    = f_l_q[rd_ptr_q];
  assign tiles_done = tiles_q;

  // Load routing, read FSM, operand pipeline and output skid FIFO next-state
  always_comb begin
    state_d     = state_q;
    a_idx_d     = a_idx_q;
    pid_d       = pid_q;
    load_bank_d = load_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    b_idx_d     = b_idx_q;
    beat_d      = beat_q;
    b_hold_d    = b_hold_q;
    mem_d       = mem_q;
    f_a_d       = f_a_q;
    f_b_d       = f_b_q;
    f_l_d       = f_l_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tiles_d     = tiles_q;
    b_in_ready  = 1'b0;
    b_fwd_valid = 1'b0;
    wrap        = 1'b0;
    rel         = 1'b0;
    issue       = 1'b0;
    iss_b       = b_hold_q;
    iss_a       = '0;
    rd_idx      = '0;
    inflight    = '0;

    // The tile owner is decided by pid as seen on word 0, held for the rest
    pid_lat    = (a_idx_q == '0) ? pid : pid_q;
    own        = (a_idx_q[A_NUM_WIDTH-1:A_PART_WIDTH] == pid_lat);
    load_full  = full_q[load_bank_q];
    a_in_ready = !load_full && (own || a_fwd_ready);
    a_fwd_valid = a_in_valid && !load_full && !own;
    a_acc      = a_in_valid && a_in_ready;
    if (a_acc) begin
      if (a_idx_q == '0) pid_d = pid;
      if (own) mem_d[load_bank_q][a_idx_q[A_PART_WIDTH-1:0]] = a_in_data;
      a_idx_d = a_idx_q + 1'b1;
      if (a_idx_q == A_MAX) begin
        wrap        = 1'b1;
        load_bank_d = !load_bank_q;
      end
    end

    // Credit reserves a FIFO slot for every read still in the pipeline
    for (int i = 0; i < RD_DELAY; i++) inflight = inflight + CNT_W'(p_v_q[i]);
    credit   = (cnt_q + inflight) < CNT_W'(DEPTH);
    iss_last = (b_idx_q == B_MAX) && (beat_q == BEAT_MAX);

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (beat_q == '0) begin
          b_in_ready  = credit && b_fwd_ready;
          b_fwd_valid = credit && b_in_valid;
          issue       = credit && b_in_valid && b_fwd_ready;
          iss_b       = b_in_data;
          if (issue) b_hold_d = b_in_data;
        end else begin
          issue = credit;
        end
        if (issue) begin
          if (beat_q == BEAT_MAX) begin
            beat_d  = '0;
            b_idx_d = b_idx_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
          if (iss_last) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        rel       = 1'b1;
        rd_bank_d = !rd_bank_q;
        state_d   = full_q[!rd_bank_q] ? ST_STREAM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A wrap and a release always address opposite banks
    if (wrap) full_d[load_bank_q] = 1'b1;
    if (rel)  full_d[rd_bank_q]   = 1'b0;

    for (int i = 0; i < LANES; i++) begin
      rd_idx = A_PART_WIDTH'(int'(beat_q) * LANES + i);
      iss_a[i*D_WIDTH +: D_WIDTH] = mem_q[rd_bank_q][rd_idx];
    end

    p_v_d[0] = issue;
    p_l_d[0] = iss_last;
    p_a_d[0] = iss_a;
    p_b_d[0] = iss_b;
    for (int i = 1; i < RD_DELAY; i++) begin
      p_v_d[i] = p_v_q[i-1];
      p_l_d[i] = p_l_q[i-1];
      p_a_d[i] = p_a_q[i-1];
      p_b_d[i] = p_b_q[i-1];
    end

    push = p_v_q[RD_DELAY-1];
    pop  = ab_valid && ab_ready;
    if (push) begin
      f_a_d[wr_ptr_q] = p_a_q[RD_DELAY-1];
      f_b_d[wr_ptr_q] = p_b_q[RD_DELAY-1];
      f_l_d[wr_ptr_q] = p_l_q[RD_DELAY-1];
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (f_l_q[rd_ptr_q]) tiles_d = tiles_q + 16'd1;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control, pipeline and FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_idx_q     <= '0;
      pid_q       <= '0;
      load_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      b_idx_q     <= '0;
      beat_q      <= '0;
      b_hold_q    <= '0;
      p_v_q       <= '0;
      p_l_q       <= '0;
      for (int i = 0; i < RD_DELAY; i++) begin
        p_a_q[i] <= '0;
        p_b_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        f_a_q[i] <= '0;
        f_b_q[i] <= '0;
      end
      f_l_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tiles_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_idx_q     <= a_idx_d;
      pid_q       <= pid_d;
      load_bank_q <= load_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      b_idx_q     <= b_idx_d;
      beat_q      <= beat_d;
      b_hold_q    <= b_hold_d;
      p_v_q       <= p_v_d;
      p_l_q       <= p_l_d;
      p_a_q       <= p_a_d;
      p_b_q       <= p_b_d;
      f_a_q       <= f_a_d;
      f_b_q       <= f_b_d;
      f_l_q       <= f_l_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      tiles_q     <= tiles_d;
    end
  end

  // A store contents; validity is tracked by full_q, so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef LOAD_AB_LANES_STATS_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;

  // Saturating stall and B-starvation counters
  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (ab_valid && !ab_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if ((state_q == ST_STREAM) && (beat_q == '0) && credit && !b_in_valid &&
        (starve_q != '1)) starve_d = starve_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_ab = stall_q;
  assign starve_b = starve_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_ab_lanes.sv
//==============================================================================
// Module      : tb_load_ab_lanes
// Description : Self-checking bench for load_ab_lanes with a queue-based
//               reference model of tile ownership, forwarding and pairing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_ab_lanes;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   pid;
  logic [63:0]  a_in_data, a_fwd_data, b_in_data, b_fwd_data, ab_b_data;
  logic         a_in_valid, a_in_ready, a_fwd_valid, a_fwd_ready;
  logic         b_in_valid, b_in_ready, b_fwd_valid, b_fwd_ready;
  logic [127:0] ab_a_data;
  logic         ab_valid, ab_ready, ab_last;
  logic [15:0]  tiles_done;

  always #5 clk = ~clk;

  load_ab_lanes dut (
    .clk(clk), .rst(rst), .pid(pid),
    .a_in_data(a_in_data), .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
    .a_fwd_data(a_fwd_data), .a_fwd_valid(a_fwd_valid), .a_fwd_ready(a_fwd_ready),
    .b_in_data(b_in_data), .b_in_valid(b_in_valid), .b_in_ready(b_in_ready),
    .b_fwd_data(b_fwd_data), .b_fwd_valid(b_fwd_valid), .b_fwd_ready(b_fwd_ready),
    .ab_a_data(ab_a_data), .ab_b_data(ab_b_data), .ab_valid(ab_valid),
    .ab_ready(ab_ready), .ab_last(ab_last), .tiles_done(tiles_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: words still to drive and pairs still expected
  logic [63:0]  a_q[$];
  logic [1:0]   a_pidq[$];
  bit           a_w0[$];
  bit           a_forq[$];
  logic [63:0]  b_q[$];
  logic [127:0] exp_a[$];
  logic [63:0]  exp_b[$];
  bit           exp_l[$];
  int           exp_tiles = 0;

  int unsigned  p_aval = 100, p_afr = 100, p_bval = 100, p_bfr = 100, p_abr = 100;
  bit           abr_pat = 1'b0;
  int           cyc = 0;
  int           n_acc = 0;
  int           n_fwd = 0;
  int           n_pop = 0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_a;
  logic [63:0]  prev_b;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One tile: A words w with pid p; owner slice is words p*4..p*4+3.
  // Pairs: for each B word j, beat t carries {A[p*4+2t+1], A[p*4+2t]}.
  task automatic add_tile(input logic [1:0] p, input bit directed);
    logic [63:0] av [16];
    logic [63:0] bv [8];
    for (int w = 0; w < 16; w++) av[w] = directed ? 64'(w) : {$urandom, $urandom};
    for (int j = 0; j < 8; j++)  bv[j] = directed ? 64'(100 + j) : {$urandom, $urandom};
    for (int w = 0; w < 16; w++) begin
      a_q.push_back(av[w]);
      a_pidq.push_back(p);
      a_w0.push_back(w == 0);
      a_forq.push_back((w / 4) != int'(p));
    end
    for (int j = 0; j < 8; j++) begin
      b_q.push_back(bv[j]);
      for (int t = 0; t < 2; t++) begin
        exp_a.push_back({av[int'(p)*4 + 2*t + 1], av[int'(p)*4 + 2*t]});
        exp_b.push_back(bv[j]);
        exp_l.push_back((j == 7) && (t == 1));
      end
    end
  endtask

  task automatic drive_inputs();
    a_in_valid  = (a_q.size() > 0) && ($urandom_range(99) < p_aval);
    a_in_data   = (a_q.size() > 0) ? a_q[0] : 64'd0;
    pid         = (a_q.size() > 0 && a_w0[0]) ? a_pidq[0] : 2'($urandom);
    a_fwd_ready = ($urandom_range(99) < p_afr);
    b_in_valid  = (b_q.size() > 0) && ($urandom_range(99) < p_bval);
    b_in_data   = (b_q.size() > 0) ? b_q[0] : 64'd0;
    b_fwd_ready = ($urandom_range(99) < p_bfr);
    ab_ready    = abr_pat ? ((cyc % 3) == 0) : ($urandom_range(99) < p_abr);
  endtask

  task automatic step();
    bit a_acc, b_acc, ab_pop, inc_tiles;
    inc_tiles = 1'b0;
    @(negedge clk);
    if (prev_stall) begin
      check_eq("ab_hold_valid", 128'(ab_valid), 128'(1'b1));
      check_eq("ab_hold_a", ab_a_data, prev_a);
      check_eq("ab_hold_b", 128'(ab_b_data), 128'(prev_b));
    end
    check_eq("tiles_done", 128'(tiles_done), 128'(exp_tiles[15:0]));
    a_acc = a_in_valid && a_in_ready;
    if (a_acc) begin
      check_eq("a_route", 128'(a_fwd_valid && a_fwd_ready), 128'(a_forq[0]));
      if (a_forq[0]) begin
        check_eq("a_fwd_data", 128'(a_fwd_data), 128'(a_q[0]));
        n_fwd++;
      end
      void'(a_q.pop_front()); void'(a_pidq.pop_front());
      void'(a_w0.pop_front()); void'(a_forq.pop_front());
      n_acc++;
    end else begin
      check_eq("a_fwd_noacc", 128'(a_fwd_valid && a_fwd_ready), 128'(1'b0));
    end
    b_acc = b_in_valid && b_in_ready;
    check_eq("b_handshake", 128'(b_fwd_valid && b_fwd_ready), 128'(b_acc));
    if (b_acc) begin
      check_eq("b_fwd_data", 128'(b_fwd_data), 128'(b_q[0]));
      void'(b_q.pop_front());
    end
    ab_pop = ab_valid && ab_ready;
    if (ab_pop) begin
      if (exp_a.size() == 0) begin
        check_eq("ab_extra", 128'(ab_pop), 128'(1'b0));
      end else begin
        check_eq("ab_a", ab_a_data, exp_a[0]);
        check_eq("ab_b", 128'(ab_b_data), 128'(exp_b[0]));
        check_eq("ab_last", 128'(ab_last), 128'(exp_l[0]));
        inc_tiles = exp_l[0];
        void'(exp_a.pop_front()); void'(exp_b.pop_front()); void'(exp_l.pop_front());
        n_pop++;
      end
    end
    prev_stall = ab_valid && !ab_ready;
    prev_a     = ab_a_data;
    prev_b     = ab_b_data;
    @(posedge clk);
    #1;
    if (inc_tiles) exp_tiles++;
    cyc++;
    drive_inputs();
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || exp_a.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_pairs_left", 128'(exp_a.size()), 128'(0));
    check_eq("drain_a_left", 128'(a_q.size()), 128'(0));
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ab_valid"}, 128'(ab_valid), 128'(0));
    check_eq({tag, "_ab_last"}, 128'(ab_last), 128'(0));
    check_eq({tag, "_tiles"}, 128'(tiles_done), 128'(0));
    check_eq({tag, "_ab_a"}, ab_a_data, 128'(0));
    check_eq({tag, "_ab_b"}, 128'(ab_b_data), 128'(0));
    check_eq({tag, "_b_rdy"}, 128'(b_in_ready), 128'(0));
    check_eq({tag, "_b_fwd_v"}, 128'(b_fwd_valid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; pid = '0;
    a_in_data = '0; a_in_valid = 1'b0; a_fwd_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_fwd_ready = 1'b0; ab_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed tile, pid 1, everything ready
    add_tile(2'd1, 1'b1);
    drive_inputs();
    run_until_done(400);
    check_eq("fwd_count", 128'(n_fwd), 128'(12));
    check_eq("tiles_one", 128'(tiles_done), 128'(1));

    // Same tile with MAC ready 1 cycle on, 2 off
    abr_pat = 1'b1;
    add_tile(2'd1, 1'b1);
    run_until_done(600);
    abr_pat = 1'b0;

    // Downstream A blocked: only the four leading own words get in
    p_afr = 0;
    base = n_acc;
    add_tile(2'd0, 1'b0);
    repeat (30) step();
    check_eq("own_first_acc", 128'(n_acc - base), 128'(4));
    check_eq("fwd_block_rdy", 128'(a_in_ready), 128'(0));
    p_afr = 100;
    run_until_done(600);

    // Three tiles with MAC stalled: the third tile must not enter
    p_abr = 0;
    base = n_acc;
    add_tile(2'($urandom), 1'b0);
    add_tile(2'($urandom), 1'b0);
    add_tile(2'($urandom), 1'b0);
    repeat (150) step();
    check_eq("two_banks_acc", 128'(n_acc - base), 128'(32));
    check_eq("third_blocked", 128'(a_in_ready), 128'(0));
    p_abr = 100;
    run_until_done(1500);

    // Randomized traffic on every handshake
    for (int t = 0; t < 6; t++) begin
      p_aval = $urandom_range(100, 30); p_afr = $urandom_range(100, 30);
      p_bval = $urandom_range(100, 30); p_bfr = $urandom_range(100, 30);
      p_abr  = $urandom_range(100, 30);
      add_tile(2'($urandom), 1'b0);
      add_tile(2'($urandom), 1'b0);
      run_until_done(3000);
    end
    p_aval = 100; p_afr = 100; p_bval = 100; p_bfr = 100; p_abr = 100;

    // Reset in the middle of a tile, then a fresh tile
    add_tile(2'd1, 1'b1);
    base = n_pop;
    for (int n = 0; n < 400 && (n_pop - base) < 7; n++) step();
    check_eq("pops_before_rst", 128'(n_pop - base), 128'(7));
    rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    a_q.delete(); a_pidq.delete(); a_w0.delete(); a_forq.delete(); b_q.delete();
    exp_a.delete(); exp_b.delete(); exp_l.delete();
    exp_tiles = 0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    add_tile(2'd1, 1'b1);
    drive_inputs();
    run_until_done(400);
    check_eq("tiles_after_rst", 128'(tiles_done), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_ab_lanes.md
Name: load_ab_lanes

Overview:
- Per-PE operand loader for the linear matrix-multiply array. Successor of the single-lane A/B loader.
- Captures this PE's slice of each A tile from the daisy-chained A stream into a double-buffered A store.
- Forwards A words owned by downstream PEs and forwards every B word.
- Streams (A[LANES], B) pairs to the MAC lanes, with full ready/valid backpressure and a runtime PE id.

Parameters:
D_WIDTH, 64, operand width in bits
LANES, 2, A operands emitted per beat; 2^A_PART_WIDTH must be a multiple of LANES
A_NUM_WIDTH, 4, log2 of A words per tile (16)
A_PART_WIDTH, 2, log2 of A words owned per PE (4)
B_NUM_WIDTH, 3, log2 of B words per tile (8)
RD_DELAY, 2, A-store read latency in cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pid  in  A_NUM_WIDTH-A_PART_WIDTH  PE id; sampled when A word 0 of a tile is accepted
a_in_data  in  D_WIDTH  A stream from upstream PE
a_in_valid  in  1  A word valid
a_in_ready  out  1  A word accepted when valid&&ready
a_fwd_data  out  D_WIDTH  A word to downstream PE (combinational copy of a_in_data)
a_fwd_valid  out  1  forward valid
a_fwd_ready  in  1  downstream ready
b_in_data  in  D_WIDTH  B stream from upstream PE
b_in_valid  in  1  B word valid
b_in_ready  out  1  B word accepted
b_fwd_data  out  D_WIDTH  B word to downstream PE
b_fwd_valid  out  1  forward valid
b_fwd_ready  in  1  downstream ready
ab_a_data  out  LANES*D_WIDTH  lane i = A entry (beat*LANES+i), lane 0 in LSBs
ab_b_data  out  D_WIDTH  B operand for the beat
ab_valid  out  1  pair valid
ab_ready  in  1  MAC ready
ab_last  out  1  final beat of a tile
tiles_done  out  16  count of completed output tiles; wraps modulo 2^16

Behaviour:
- Reset: all outputs 0; both banks empty; load and read bank index 0; all counters 0.
- Reset mid-tile discards all state; no partial tile is ever emitted.
- A load counter a_idx (A_NUM_WIDTH bits):
  - Word is "own" when pid_lat*2^A_PART_WIDTH <= a_idx < (pid_lat+1)*2^A_PART_WIDTH.
  - Otherwise it is "foreign". pid_lat = pid at a_idx==0, else the registered value.
  - Comparison uses the pid input directly on a_idx==0.
- A handshake:
  - a_in_ready = !load_bank_full && (own || a_fwd_ready).
  - a_fwd_valid = a_in_valid && !load_bank_full && foreign.
  - Own words are written to {load_bank, a_idx - base} and never forwarded.
- a_idx increments per accepted word and wraps to 0 after 2^A_NUM_WIDTH-1.
  - On that wrap, load_bank is marked full and load_bank toggles.
  - If the new load bank is still full, a_in_ready stays 0 until it is released.
- Read FSM states:
  - IDLE: go to STREAM when the read bank is full.
  - STREAM: emit beats.
  - RELEASE: one cycle; mark the read bank empty, toggle the read bank; then STREAM if the other bank is full, else IDLE.
- STREAM ordering:
  - For each b_idx in 0..2^B_NUM_WIDTH-1, emit beats 0..(2^A_PART_WIDTH/LANES)-1.
  - The B word is consumed on beat 0: b_in_ready = STREAM && beat==0 && credit && b_fwd_ready.
  - b_fwd_valid = STREAM && beat==0 && credit && b_in_valid.
  - The consumed B word is held in a register for the remaining beats.
  - Beats 1..n issue A reads when credit is available; they do not depend on B.
- Output path:
  - A reads have RD_DELAY latency; pair data is aligned into an output skid FIFO of depth RD_DELAY+1.
  - credit = free FIFO slots minus reads in flight > 0.
  - No pair is dropped or duplicated under any ab_ready pattern.
- ab_last is set on the beat with b_idx max and beat max.
  - After that beat is issued: RELEASE, then tiles_done+1 when it leaves the FIFO.
- Simultaneous events:
  - Load-wrap and RELEASE in the same cycle: both take effect, so loading resumes into the just-released bank next cycle.
  - b_in_valid low in STREAM beat 0 stalls with no output.

Optional Feature:
LOAD_AB_LANES_STATS_EN:
- Defined: adds ports stall_ab out 32 and starve_b out 32.
  - stall_ab counts cycles with ab_valid&&!ab_ready.
  - starve_b counts STREAM beat-0 cycles with credit and !b_in_valid.
  - Both saturate at 2^32-1 and are cleared by rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- pid=1, 16 A words 0..15, a_fwd_ready=1 -> words 4..7 stored; 0..3 and 8..15 appear on a_fwd; 12 fwd beats.
- One tile, B=100..107, ab_ready=1 -> 16 beats; beat k carries A{4+2(k%2), 5+2(k%2)} and B=100+k/2; ab_last only on beat 15; tiles_done=1.
- ab_ready toggled 1 cycle on / 2 off -> same 16 beats in order, none lost; ab_valid held stable while stalled.
- Three tiles back-to-back with the MAC stalled -> third tile blocks (a_in_ready=0) after two banks fill; resumes in the cycle after first RELEASE.
- a_fwd_ready=0 for a foreign word -> a_in_ready=0 and a_idx frozen; own words still accepted when they arrive first.
- rst asserted at beat 7 -> all outputs 0 next cycle; new full tile afterwards produces a correct 16-beat sequence with tiles_done=1.
